// File: rtl/mode_ctrl.sv
// -----------------------------------------------------------------------------
// mode_ctrl
//
// Top-level mode controller for the clock / stopwatch / timer / alarm board.
//   * Edge-detects the five shared push-buttons and routes the C/L/D/R press
//     pulses only to the bus of the currently selected mode engine.
//   * Steps the mode CLOCK -> STOPWATCH -> TIMER -> ALARM -> CLOCK on a bU
//     press, unless the current mode reports an edit in progress.
//   * Generates the common tick_ms enable (CLK_HZ/TICK_HZ clocks per tick).
//   * Raises beep on a rising edge of timer_done or alarm_hit and retires it
//     after BEEP_MS ticks or on any button press (acknowledge).
//
// Optional feature macro: MODE_CTRL_AUTO_JUMP_EN
//   Defined   : a timer_done rising edge forces mode=TIMER on the same cycle
//               the beep starts, overriding bU and edit.
//   Undefined : timer_done never changes the mode.
//
// Ports
//   clk                      in   system clock
//   rst                      in   synchronous active-high reset
//   bU                       in   debounced mode-select button level
//   bC, bL, bD, bR           in   debounced shared edit button levels
//   edit[3:0]                in   per-mode edit-active flags, index = mode
//   timer_done               in   countdown-timer done level
//   alarm_hit                in   alarm-match level
//   mode[1:0]                out  0=CLOCK 1=STOPWATCH 2=TIMER 3=ALARM
//   btn_clk/sw/tmr/alm[3:0]  out  one-cycle press pulses {C,L,D,R}
//   tick_ms                  out  one-cycle enable at TICK_HZ
//   beep                     out  buzzer request
// -----------------------------------------------------------------------------
module mode_ctrl #(
   parameter int CLK_HZ  = 100000000,
   parameter int TICK_HZ = 1000,
   parameter int BEEP_MS = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bU,
   input  logic       bC,
   input  logic       bL,
   input  logic       bD,
   input  logic       bR,
   input  logic [3:0] edit,
   input  logic       timer_done,
   input  logic       alarm_hit,
   output logic [1:0] mode,
   output logic [3:0] btn_clk,
   output logic [3:0] btn_sw,
   output logic [3:0] btn_tmr,
   output logic [3:0] btn_alm,
   output logic       tick_ms,
   output logic       beep
);

   localparam int DIV    = CLK_HZ / TICK_HZ;
   localparam int DIV_W  = $clog2(DIV);
   localparam int BEEP_W = $clog2(BEEP_MS + 1);

   localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(DIV - 1);
   localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_MS);

   typedef enum logic [1:0] {
      MODE_CLOCK     = 2'd0,
      MODE_STOPWATCH = 2'd1,
      MODE_TIMER     = 2'd2,
      MODE_ALARM     = 2'd3
   } mode_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BEEP = 1'b1
   } beep_state_t;

   // ---------------------------------------------------------------------------
   // Button edge detection. Bit order {U,C,L,D,R}.
   // r_btn_lvl is the registered level; r_btn_prev is its one-cycle history.
   // On the first cycle after reset the history is loaded straight from the
   // input, so a button held through reset never produces a pulse.
   // ---------------------------------------------------------------------------
   logic [4:0] w_btn_in;
   logic [4:0] r_btn_lvl;
   logic [4:0] r_btn_prev;
   logic       r_armed;
   logic [4:0] w_rise;
   logic       w_rise_u;
   logic [3:0] w_rise_e;
   logic       w_any_press;

   assign w_btn_in    = {bU, bC, bL, bD, bR};
   assign w_rise      = r_btn_lvl & ~r_btn_prev;
   assign w_rise_u    = w_rise[4];
   assign w_rise_e    = w_rise[3:0];
   assign w_any_press = |w_rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_btn_lvl  <= '0;
         r_btn_prev <= '0;
         r_armed    <= 1'b0;
      end else begin
         r_btn_lvl  <= w_btn_in;
         r_btn_prev <= r_armed ? r_btn_lvl : w_btn_in;
         r_armed    <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Event edge detection for timer_done / alarm_hit.
   // ---------------------------------------------------------------------------
   logic r_td_q;
   logic r_ah_q;
   logic w_td_rise;
   logic w_ah_rise;
   logic w_evt;

   assign w_td_rise = timer_done & ~r_td_q;
   assign w_ah_rise = alarm_hit & ~r_ah_q;
   assign w_evt     = w_td_rise | w_ah_rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_td_q <= 1'b0;
         r_ah_q <= 1'b0;
      end else begin
         r_td_q <= timer_done;
         r_ah_q <= alarm_hit;
      end
   end

   // ---------------------------------------------------------------------------
   // Millisecond tick divider: free-running, never gated by mode or beep.
   // ---------------------------------------------------------------------------
   logic [DIV_W-1:0] r_div;
   logic             r_tick;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= (r_div == DIV_MAX);
         r_div  <= (r_div == DIV_MAX) ? '0 : r_div + DIV_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Beep FSM. While beeping, every press is an acknowledge and is swallowed
   // (w_consume) so it neither routes nor changes the mode. A new event on the
   // same cycle as an acknowledge keeps the beep alive with a fresh count.
   // ---------------------------------------------------------------------------
   beep_state_t       r_state;
   beep_state_t       w_state_next;
   logic [BEEP_W-1:0] r_beep_cnt;
   logic [BEEP_W-1:0] w_beep_cnt_next;
   logic              w_consume;
   logic              r_beep;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_beep_cnt <= '0;
         r_beep     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_beep_cnt <= w_beep_cnt_next;
         r_beep     <= (w_state_next == ST_BEEP);
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_beep_cnt_next = r_beep_cnt;
      w_consume       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_evt) begin
               w_state_next    = ST_BEEP;
               w_beep_cnt_next = BEEP_LOAD;
            end
         end
         ST_BEEP: begin
            w_consume = 1'b1;
            if (w_evt) begin
               w_beep_cnt_next = BEEP_LOAD;
            end else if (w_any_press) begin
               w_state_next    = ST_IDLE;
               w_beep_cnt_next = '0;
            end else if (r_tick) begin
               // Terminal tick is the one that takes the count to zero.
               if (r_beep_cnt <= BEEP_W'(1)) begin
                  w_state_next    = ST_IDLE;
                  w_beep_cnt_next = '0;
               end else begin
                  w_beep_cnt_next = r_beep_cnt - BEEP_W'(1);
               end
            end
         end
         default: begin
            w_state_next    = ST_IDLE;
            w_beep_cnt_next = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Mode FSM. Updated on the same edge that registers the routed pulses, so
   // a mode change is visible exactly when a bU pulse would have been.
   // ---------------------------------------------------------------------------
   mode_t r_mode;
   mode_t w_mode_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode <= MODE_CLOCK;
      end else begin
         r_mode <= w_mode_next;
      end
   end

   always_comb begin
      w_mode_next = r_mode;
      if (w_rise_u && !w_consume && !edit[r_mode]) begin
         case (r_mode)
            MODE_CLOCK:     w_mode_next = MODE_STOPWATCH;
            MODE_STOPWATCH: w_mode_next = MODE_TIMER;
            MODE_TIMER:     w_mode_next = MODE_ALARM;
            MODE_ALARM:     w_mode_next = MODE_CLOCK;
            default:        w_mode_next = MODE_CLOCK;
         endcase
      end
`ifdef MODE_CTRL_AUTO_JUMP_EN
      if (w_td_rise) begin
         w_mode_next = MODE_TIMER;
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // Pulse routing. A bU press or a beep acknowledge drops the C/L/D/R pulses
   // of that cycle entirely; otherwise only the current mode's bus is driven.
   // ---------------------------------------------------------------------------
   logic [3:0]      w_route;
   logic [3:0][3:0] w_btn_next;
   logic [3:0][3:0] r_btn;

   assign w_route = (w_rise_u || w_consume) ? 4'b0000 : w_rise_e;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_route
         assign w_btn_next[gi] = (r_mode == mode_t'(gi)) ? w_route : 4'b0000;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_btn <= '0;
      end else begin
         r_btn <= w_btn_next;
      end
   end

   assign mode    = r_mode;
   assign btn_clk = r_btn[0];
   assign btn_sw  = r_btn[1];
   assign btn_tmr = r_btn[2];
   assign btn_alm = r_btn[3];
   assign tick_ms = r_tick;
   assign beep    = r_beep;

endmodule
